mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 55 +++++
 rtl/mem_stage_if.sv | 39 +++
 rtl/mem_stage_load_align.sv | 57 +++++
 rtl/mem_stage.sv | 86 ++++++++
 tb/tb_mem_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, load-control encodings and bus layouts for the MEM pipeline stage.
// Anything that must agree between EXE, MEM and WB lives here.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int MS_TO_WS_BUS_WD = 73;
  localparam int ES_EX_BUS_WD    = 10;
  localparam int ES_LOAD_BUS_WD  = 7;

  typedef enum logic [1:0] {
    LD_UNALIGNED = 2'b00,
    LD_BYTE      = 2'b01,
    LD_HALF      = 2'b10,
    LD_WORD      = 2'b11
  } ld_width_e;

  typedef enum logic [1:0] {
    LR_NONE  = 2'b00,
    LR_RIGHT = 2'b01,
    LR_LEFT  = 2'b10
  } ld_lr_e;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    ld_width_e  width;
    logic       sign;
    ld_lr_e     lr;
    logic [1:0] addr;
  } load_t;

  typedef struct packed {
    logic       bd;
    logic       sys;
    logic       mfc0;
    logic       mtc0;
    logic       eret;
    logic [4:0] c0_addr;
  } ex_t;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sign);
    return {{24{sign & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sign);
    return {{16{sign & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EXE->MEM->WB handshake, load side-band and forwarding signals of the MEM stage.
// master: the surrounding pipeline; slave: the MEM stage itself.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [ES_LOAD_BUS_WD-1:0]  es_load_mem_bus;
  logic [ES_EX_BUS_WD-1:0]    es_ex_bus;
  logic [31:0]                data_sram_rdata;
  logic                       flush;

  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [ES_EX_BUS_WD-1:0]    ms_ex_bus;
  logic                       ms_write_reg;
  logic [4:0]                 ms_reg_dest;
  logic [31:0]                ms_to_ds_bus;
  logic [3:0]                 ms_fwd_bwe;
  logic                       ms_mfc0_stall;
  logic                       ms_ex;

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, es_load_mem_bus, es_ex_bus,
           data_sram_rdata, flush,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_ex_bus, ms_write_reg,
           ms_reg_dest, ms_to_ds_bus, ms_fwd_bwe, ms_mfc0_stall, ms_ex
  );

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, es_load_mem_bus, es_ex_bus,
           data_sram_rdata, flush,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_ex_bus, ms_write_reg,
           ms_reg_dest, ms_to_ds_bus, ms_fwd_bwe, ms_mfc0_stall, ms_ex
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks byte/half/word or LWL/LWR merge data
// out of the raw SRAM word and reports which register bytes it writes.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  load_t       ld,
  input  logic [31:0] rdata,
  output logic [31:0] result,
  output logic [3:0]  bwe
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[7:0];
    case (ld.addr)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
    endcase
    sel_half = ld.addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // LWL fills the register from the top down, LWR from the bottom up.
  always_comb begin
    result = rdata;
    bwe    = 4'b1111;
    case (ld.width)
      LD_WORD: begin
        result = rdata;
        bwe    = 4'b1111;
      end
      LD_HALF: result = ext_half(sel_half, ld.sign);
      LD_BYTE: result = ext_byte(sel_byte, ld.sign);
      LD_UNALIGNED: begin
        if (ld.lr == LR_LEFT) begin
          case (ld.addr)
            2'd0: begin result = {rdata[7:0], 24'b0};  bwe = 4'b1000; end
            2'd1: begin result = {rdata[15:0], 16'b0}; bwe = 4'b1100; end
            2'd2: begin result = {rdata[23:0], 8'b0};  bwe = 4'b1110; end
            2'd3: begin result = rdata;                bwe = 4'b1111; end
          endcase
        end else if (ld.lr == LR_RIGHT) begin
          case (ld.addr)
            2'd0: begin result = rdata;                bwe = 4'b1111; end
            2'd1: begin result = {8'b0, rdata[31:8]};  bwe = 4'b0111; end
            2'd2: begin result = {16'b0, rdata[31:16]}; bwe = 4'b0011; end
            2'd3: begin result = {24'b0, rdata[31:24]}; bwe = 4'b0001; end
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE bus, aligns load data from the synchronous
// SRAM and hands results to WB while forwarding them back to decode.
module mem_stage
  import mem_stage_pkg::*;
(
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave bus
);

  logic        ms_valid;
  logic        allowin;
  es_to_ms_t   es_r;
  load_t       ld_r;
  ex_t         ex_r;
  logic        rdata_held;
  logic [31:0] rdata_hold;
  logic [31:0] load_data;
  logic [31:0] load_result;
  logic [3:0]  load_bwe;
  logic [31:0] final_result;
  logic [3:0]  result_bwe;
  logic [3:0]  rf_bwe;

  assign allowin = !ms_valid || bus.ws_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (bus.flush) begin
      ms_valid <= 1'b0;
    end else if (allowin) begin
      ms_valid <= bus.es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_r <= '0;
      ld_r <= '0;
      ex_r <= '0;
    end else if (bus.es_to_ms_valid && allowin) begin
      es_r <= es_to_ms_t'(bus.es_to_ms_bus);
      ld_r <= load_t'(bus.es_load_mem_bus);
      ex_r <= ex_t'(bus.es_ex_bus);
    end
  end

  // The SRAM only presents the word for one cycle, so park it once WB stalls us.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_held <= 1'b0;
      rdata_hold <= '0;
    end else if (allowin || bus.flush) begin
      rdata_held <= 1'b0;
    end else if (ms_valid && !bus.ws_allowin && !rdata_held) begin
      rdata_held <= 1'b1;
      rdata_hold <= bus.data_sram_rdata;
    end
  end

  assign load_data = rdata_held ? rdata_hold : bus.data_sram_rdata;

  mem_load_align u_align (
    .ld     (ld_r),
    .rdata  (load_data),
    .result (load_result),
    .bwe    (load_bwe)
  );

  assign final_result = es_r.res_from_mem ? load_result : es_r.alu_result;
  assign result_bwe   = es_r.res_from_mem ? load_bwe : 4'b1111;
  assign rf_bwe       = (es_r.gr_we && ms_valid) ? result_bwe : 4'b0000;

  assign bus.ms_allowin     = allowin;
  assign bus.ms_to_ws_valid = ms_valid;
  assign bus.ms_to_ws_bus   = {rf_bwe, es_r.dest, final_result, es_r.pc};
  assign bus.ms_ex_bus      = ex_r;
  assign bus.ms_write_reg   = es_r.gr_we && ms_valid;
  assign bus.ms_reg_dest    = es_r.dest;
  assign bus.ms_to_ds_bus   = final_result;
  assign bus.ms_fwd_bwe     = rf_bwe;
  assign bus.ms_mfc0_stall  = ex_r.mfc0 && ms_valid;
  assign bus.ms_ex          = (ex_r.sys || ex_r.eret) && ms_valid;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/stall/flush/reset steps followed
// by random traffic compared against a transaction-level model of the stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  // Model: the entry currently in MEM and the SRAM word it observed on arrival.
  logic        m_valid;
  logic        m_first;
  logic [70:0] m_es;
  logic [6:0]  m_ld;
  logic [9:0]  m_ex;
  logic [31:0] m_data;

  mem_stage_if bus();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [72:0] observed, input logic [72:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  function automatic logic [70:0] mkEs(input logic res, input logic we, input logic [4:0] dest,
                                       input logic [31:0] alu, input logic [31:0] pc);
    return {res, we, dest, alu, pc};
  endfunction

  function automatic logic [6:0] mkLd(input logic [1:0] w, input logic s, input logic [1:0] lr,
                                      input logic [1:0] a);
    return {w, s, lr, a};
  endfunction

  // Returns {byte-enables, value} for a load of word d, computed by shifting.
  function automatic logic [35:0] refLoad(input logic [6:0] ld, input logic [31:0] d);
    logic [31:0] v;
    logic [3:0]  m;
    int          a;
    a = int'(ld[1:0]);
    v = d;
    m = 4'hf;
    case (ld[6:5])
      2'b10: begin
        v = (d >> (16 * int'(ld[1]))) & 32'h0000_ffff;
        if (ld[4] && v[15]) v = v | 32'hffff_0000;
      end
      2'b01: begin
        v = (d >> (8 * a)) & 32'h0000_00ff;
        if (ld[4] && v[7]) v = v | 32'hffff_ff00;
      end
      2'b00: begin
        if (ld[3:2] == 2'b10) begin
          v = d << (8 * (3 - a));
          m = 4'hf << (3 - a);
        end else if (ld[3:2] == 2'b01) begin
          v = d >> (8 * a);
          m = 4'hf >> a;
        end
      end
      default: ;
    endcase
    return {m, v};
  endfunction

  task automatic checkAll();
    logic [35:0] ld_exp;
    logic [31:0] res;
    logic [3:0]  bwe;
    ld_exp = refLoad(m_ld, m_data);
    if (m_es[70]) begin
      res = ld_exp[31:0];
      bwe = ld_exp[35:32];
    end else begin
      res = m_es[63:32];
      bwe = 4'hf;
    end
    if (!m_es[69]) bwe = 4'h0;
    checkOutput("ms_allowin", 73'(bus.ms_allowin), 73'(!m_valid || bus.ws_allowin));
    checkOutput("ms_to_ws_valid", 73'(bus.ms_to_ws_valid), 73'(m_valid));
    checkOutput("ms_ex_bus", 73'(bus.ms_ex_bus), 73'(m_ex));
    checkOutput("ms_reg_dest", 73'(bus.ms_reg_dest), 73'(m_es[68:64]));
    checkOutput("ms_write_reg", 73'(bus.ms_write_reg), 73'(m_valid && m_es[69]));
    checkOutput("ms_mfc0_stall", 73'(bus.ms_mfc0_stall), 73'(m_valid && m_ex[7]));
    checkOutput("ms_ex", 73'(bus.ms_ex), 73'(m_valid && (m_ex[8] || m_ex[5])));
    if (m_valid) begin
      checkOutput("ms_to_ws_bus", bus.ms_to_ws_bus, {bwe, m_es[68:64], res, m_es[31:0]});
      checkOutput("ms_to_ds_bus", 73'(bus.ms_to_ds_bus), 73'(res));
      checkOutput("ms_fwd_bwe", 73'(bus.ms_fwd_bwe), 73'(bwe));
    end else begin
      checkOutput("idle_fwd_bwe", 73'(bus.ms_fwd_bwe), 73'(4'h0));
      checkOutput("idle_ws_bwe", 73'(bus.ms_to_ws_bus[72:69]), 73'(4'h0));
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic [70:0] es, input logic [6:0] ld,
                               input logic [9:0] ex, input logic ws, input logic fl,
                               input logic [31:0] rd);
    bus.es_to_ms_valid  = ev;
    bus.es_to_ms_bus    = es;
    bus.es_load_mem_bus = ld;
    bus.es_ex_bus       = ex;
    bus.ws_allowin      = ws;
    bus.flush           = fl;
    bus.data_sram_rdata = rd;
    if (m_first) m_data = rd;
    #1;
    checkAll();
  endtask

  task automatic tick();
    logic alw;
    logic take;
    logic nv;
    alw  = !m_valid || bus.ws_allowin;
    take = bus.es_to_ms_valid && alw;
    if (bus.flush) nv = 1'b0;
    else if (alw) nv = bus.es_to_ms_valid;
    else nv = m_valid;
    @(posedge clk);
    #1;
    m_valid = nv;
    m_first = take;
    if (take) begin
      m_es = bus.es_to_ms_bus;
      m_ld = bus.es_load_mem_bus;
      m_ex = bus.es_ex_bus;
    end
  endtask

  task automatic modelReset();
    m_valid = 1'b0;
    m_first = 1'b0;
    m_es    = '0;
    m_ld    = '0;
    m_ex    = '0;
    m_data  = '0;
  endtask

  task automatic loadOnce(input string tag, input logic [6:0] ld, input logic [31:0] rd,
                          input logic [31:0] exp_val, input logic [3:0] exp_bwe);
    applyStimulus(1'b1, mkEs(1'b1, 1'b1, 5'd7, 32'h0bad_0bad, 32'hbfc0_0100), ld, 10'h0,
                  1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, rd);
    checkOutput({tag, "_value"}, 73'(bus.ms_to_ws_bus[63:32]), 73'(exp_val));
    checkOutput({tag, "_bwe"}, 73'(bus.ms_fwd_bwe), 73'(exp_bwe));
    tick();
  endtask

  initial begin
    logic [6:0] rld;
    compared   = 0;
    mismatched = 0;
    modelReset();
    reset = 1'b1;
    bus.es_to_ms_valid  = 1'b0;
    bus.es_to_ms_bus    = '0;
    bus.es_load_mem_bus = '0;
    bus.es_ex_bus       = '0;
    bus.ws_allowin      = 1'b0;
    bus.flush           = 1'b0;
    bus.data_sram_rdata = 32'h1234_5678;
    #3;
    checkAll();
    checkOutput("reset_ws_bus", bus.ms_to_ws_bus, 73'h0);
    checkOutput("reset_ds_bus", 73'(bus.ms_to_ds_bus), 73'h0);
    checkOutput("reset_allowin", 73'(bus.ms_allowin), 73'h1);
    @(negedge clk);
    reset = 1'b0;

    // Aligned and sub-word loads with known answers.
    loadOnce("lw", mkLd(2'b11, 1'b0, 2'b00, 2'd0), 32'h8899_aabb, 32'h8899_aabb, 4'b1111);
    loadOnce("lb_signed", mkLd(2'b01, 1'b1, 2'b00, 2'd3), 32'h8000_0000, 32'hffff_ff80, 4'b1111);
    loadOnce("lbu", mkLd(2'b01, 1'b0, 2'b00, 2'd3), 32'h8000_0000, 32'h0000_0080, 4'b1111);
    loadOnce("lh_signed", mkLd(2'b10, 1'b1, 2'b00, 2'd2), 32'h9abc_1234, 32'hffff_9abc, 4'b1111);
    loadOnce("lwl_a1", mkLd(2'b00, 1'b0, 2'b10, 2'd1), 32'h1122_3344, 32'h3344_0000, 4'b1100);
    loadOnce("lwr_a2", mkLd(2'b00, 1'b0, 2'b01, 2'd2), 32'h1122_3344, 32'h0000_1122, 4'b0011);

    // WB stall for three cycles while the SRAM output drifts.
    applyStimulus(1'b1, mkEs(1'b1, 1'b1, 5'd9, 32'h0, 32'hbfc0_0200), mkLd(2'b11, 1'b0, 2'b00, 2'd0),
                  10'h080, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 32'h5566_7788);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 32'hdead_beef);
    checkOutput("stall_hold_c2", 73'(bus.ms_to_ds_bus), 73'(32'h5566_7788));
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 32'hdead_beef);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 32'hdead_beef);
    checkOutput("stall_handoff", 73'(bus.ms_to_ds_bus), 73'(32'h5566_7788));
    tick();

    // Flush a stalled entry that already holds its data.
    applyStimulus(1'b1, mkEs(1'b1, 1'b1, 5'd4, 32'h0, 32'hbfc0_0300), mkLd(2'b11, 1'b0, 2'b00, 2'd0),
                  10'h100, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 32'hcafe_f00d);
    tick();
    checkOutput("held_before_flush", 73'(dut.rdata_held), 73'h1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 32'h0);
    checkOutput("flush_valid", 73'(bus.ms_to_ws_valid), 73'h0);
    checkOutput("flush_write_reg", 73'(bus.ms_write_reg), 73'h0);
    checkOutput("flush_held", 73'(dut.rdata_held), 73'h0);

    // Asynchronous reset in the middle of a stall.
    applyStimulus(1'b1, mkEs(1'b0, 1'b1, 5'd2, 32'h7777_0000, 32'hbfc0_0400), mkLd(2'b11, 1'b0, 2'b00, 2'd0),
                  10'h020, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 32'h0101_0101);
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_valid", 73'(bus.ms_to_ws_valid), 73'h0);
    checkOutput("async_reset_allowin", 73'(bus.ms_allowin), 73'h1);
    checkOutput("async_reset_ws_bus", bus.ms_to_ws_bus, 73'h0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rld = 7'($urandom);
      if (rld[6:5] == 2'b00) rld[3:2] = ($urandom % 2 == 0) ? 2'b10 : 2'b01;
      applyStimulus(($urandom % 4) != 0, 71'({$urandom, $urandom, $urandom}), rld, 10'($urandom),
                    ($urandom % 3) != 0, ($urandom % 16) == 0, $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
